// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types and constants: component tags and block geometry.
package jpeg_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    localparam int COEF_W    = 11;
    localparam int BLK_BEATS = 64;
    localparam int BEAT_W    = $clog2(BLK_BEATS);
    localparam int IDX_W     = 3;

    // Schedule entry -> component: Y_PER_MCU luma blocks, then Cb, then Cr.
    function automatic comp_t sched_comp(input logic [IDX_W-1:0] idx, input int y_per_mcu);
        if (int'(idx) < y_per_mcu) begin
            return COMP_Y;
        end else if (int'(idx) == y_per_mcu) begin
            return COMP_CB;
        end
        return COMP_CR;
    endfunction

endpackage

// File: rtl/mcu_seq.sv
// MCU position tracker: 64-beat block counter plus schedule index that wraps
// after the Cr block. Advances only on transfers.
module mcu_seq
    import jpeg_pkg::*;
#(
    parameter int Y_PER_MCU = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  adv_i,
    output comp_t comp_o,
    output logic  sob_o,
    output logic  eob_o,
    output logic  eom_o
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(Y_PER_MCU + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_BEATS - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        beat_d = beat_q;
        idx_d  = idx_q;
        if (adv_i) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            idx_q  <= '0;
        end else begin
            beat_q <= beat_d;
            idx_q  <= idx_d;
        end
    end

    assign comp_o = sched_comp(idx_q, Y_PER_MCU);
    assign sob_o  = (beat_q == '0);
    assign eob_o  = (beat_q == LAST_BEAT);
    assign eom_o  = eob_o && (comp_o == COMP_CR);

endmodule

// File: rtl/mcu_sched.sv
// Shares one zigzag block between the Y/Cb/Cr coefficient streams in MCU order,
// limits blocks in flight to the zigzag double buffer, and tags its output.
module mcu_sched
    import jpeg_pkg::*;
#(
    parameter int Y_PER_MCU = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             src_ena_in,
    input  logic [2:0][COEF_W-1:0] src_in,
    output logic [2:0]             src_rdy_out,
    output logic                   zz_ena_out,
    output logic [COEF_W-1:0]      zz_out,
    input  logic                   zz_rdy_in,
    input  logic                   zz_ena_in,
    input  logic [COEF_W-1:0]      zz_in,
    output logic                   zz_rdy_out,
    output logic                   ena_out,
    output logic [COEF_W-1:0]      out,
    input  logic                   rdy_in,
    output logic [1:0]             comp_out,
    output logic                   sob_out,
    output logic                   eob_out,
    output logic                   eom_out,
    output logic                   err_out
);

    comp_t in_comp, out_comp;
    logic  in_sob, in_eob, in_eom;
    logic  out_sob, out_eob, out_eom;
    logic  in_xfer, out_xfer, stall;
    logic  inc, dec;
    logic  unused_in_flags;

    logic [1:0] infl_q, infl_d;
    logic       err_q, err_d;

    mcu_seq #(.Y_PER_MCU(Y_PER_MCU)) u_in_seq (
        .clk   (clk),
        .rst   (rst),
        .adv_i (in_xfer),
        .comp_o(in_comp),
        .sob_o (in_sob),
        .eob_o (in_eob),
        .eom_o (in_eom)
    );

    mcu_seq #(.Y_PER_MCU(Y_PER_MCU)) u_out_seq (
        .clk   (clk),
        .rst   (rst),
        .adv_i (out_xfer),
        .comp_o(out_comp),
        .sob_o (out_sob),
        .eob_o (out_eob),
        .eom_o (out_eom)
    );

    assign unused_in_flags = in_eob ^ in_eom;

    // Only a block that has not yet started may be held back.
    assign stall = (infl_q == 2'd2) && in_sob;

    always_comb begin
        src_rdy_out = '0;
        if (!rst) begin
            src_rdy_out[in_comp] = zz_rdy_in && !stall;
        end
    end

    assign zz_ena_out = !rst && src_ena_in[in_comp] && !stall;
    assign zz_out     = src_in[in_comp];
    assign in_xfer    = zz_ena_out && zz_rdy_in;

    assign zz_rdy_out = !rst && rdy_in;
    assign ena_out    = zz_ena_in;
    assign out        = zz_in;
    assign out_xfer   = zz_ena_in && rdy_in;

    assign comp_out = out_comp;
    assign sob_out  = ena_out && out_sob;
    assign eob_out  = ena_out && out_eob;
    assign eom_out  = ena_out && out_eom;

    assign inc = in_xfer && in_sob;
    assign dec = out_xfer && out_eob;

    always_comb begin
        infl_d = infl_q;
        err_d  = err_q;
        if (inc && !dec) begin
            infl_d = infl_q + 2'd1;
        end else if (dec && !inc && (infl_q != 2'd0)) begin
            infl_d = infl_q - 2'd1;
        end
        if (zz_ena_in && (infl_q == 2'd0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            infl_q <= infl_d;
            err_q  <= err_d;
        end
    end

    assign err_out = err_q;

endmodule

// File: tb/tb_mcu_sched.sv
// Bench for mcu_sched: behavioural sources and zigzag around the DUT, with an
// expected-output queue filled as source blocks are loaded.
module tb_mcu_sched;

    typedef struct {
        int data;
        int comp;
        bit sob;
        bit eob;
        bit eom;
    } exp_t;

    logic             clk;
    logic             rst_a     [2];
    logic [2:0]       s_ena_a   [2];
    logic [2:0][10:0] s_in_a    [2];
    logic [2:0]       s_rdy_a   [2];
    logic             zen_o_a   [2];
    logic [10:0]      zout_a    [2];
    logic             zrdy_a    [2];
    logic             zen_i_a   [2];
    logic [10:0]      zin_a     [2];
    logic             zrdy_o_a  [2];
    logic             ena_a     [2];
    logic [10:0]      out_a     [2];
    logic             rdyin_a   [2];
    logic [1:0]       comp_a    [2];
    logic             sob_a     [2];
    logic             eob_a     [2];
    logic             eom_a     [2];
    logic             err_a     [2];

    mcu_sched #(.Y_PER_MCU(4)) dut0 (
        .clk(clk), .rst(rst_a[0]), .src_ena_in(s_ena_a[0]), .src_in(s_in_a[0]),
        .src_rdy_out(s_rdy_a[0]), .zz_ena_out(zen_o_a[0]), .zz_out(zout_a[0]),
        .zz_rdy_in(zrdy_a[0]), .zz_ena_in(zen_i_a[0]), .zz_in(zin_a[0]),
        .zz_rdy_out(zrdy_o_a[0]), .ena_out(ena_a[0]), .out(out_a[0]), .rdy_in(rdyin_a[0]),
        .comp_out(comp_a[0]), .sob_out(sob_a[0]), .eob_out(eob_a[0]), .eom_out(eom_a[0]),
        .err_out(err_a[0])
    );

    mcu_sched #(.Y_PER_MCU(1)) dut1 (
        .clk(clk), .rst(rst_a[1]), .src_ena_in(s_ena_a[1]), .src_in(s_in_a[1]),
        .src_rdy_out(s_rdy_a[1]), .zz_ena_out(zen_o_a[1]), .zz_out(zout_a[1]),
        .zz_rdy_in(zrdy_a[1]), .zz_ena_in(zen_i_a[1]), .zz_in(zin_a[1]),
        .zz_rdy_out(zrdy_o_a[1]), .ena_out(ena_a[1]), .out(out_a[1]), .rdy_in(rdyin_a[1]),
        .comp_out(comp_a[1]), .sob_out(sob_a[1]), .eob_out(eob_a[1]), .eom_out(eom_a[1]),
        .err_out(err_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   u = 0;
    int   ypm = 4;
    bit   rst_v = 1, rdy_v = 1, zz_rdy_v = 1, force_zz = 0;
    bit   mask [3] = '{1, 1, 1};
    int   q0[$], q1[$], q2[$];
    exp_t exp_q[$];
    int   zq[$];
    int   zz [64];
    int   wr_buf [64];
    int   m_ibeat, m_iidx, m_obeat, m_infl;
    bit   err_exp;
    int   cyc = 0, blocks_in = 0;
    int   obeat_cnt, eom_cnt, eom_at;
    int   first_eob, first_start;
    bit   track = 0;
    int   comp_log[$];

    function automatic int comp_of(input int idx);
        if (idx < ypm) return 0;
        if (idx == ypm) return 1;
        return 2;
    endfunction

    function automatic int src_size(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int src_front(input int s);
        if (src_size(s) == 0) return 0;
        case (s)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void src_pop(input int s);
        case (s)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void src_push(input int s, input int v);
        case (s)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic void load_blk(input int s);
        for (int j = 0; j < 64; j++) src_push(s, s * 100 + j);
    endfunction

    function automatic void push_exp();
        exp_t e;
        for (int k = 0; k < ypm + 2; k++) begin
            for (int j = 0; j < 64; j++) begin
                e.comp = comp_of(k);
                e.data = e.comp * 100 + zz[j];
                e.sob  = (j == 0);
                e.eob  = (j == 63);
                e.eom  = (j == 63) && (e.comp == 2);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void load_mcu();
        for (int b = 0; b < ypm; b++) load_blk(0);
        load_blk(1);
        load_blk(2);
        push_exp();
    endfunction

    function automatic void reset_model();
        m_ibeat = 0; m_iidx = 0; m_obeat = 0; m_infl = 0; err_exp = 0;
        zq.delete(); q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
    endfunction

    task automatic drive();
        logic [2:0]       e;
        logic [2:0][10:0] d;
        for (int v = 0; v < 2; v++) begin
            if (v != u) begin
                rst_a[v] = 1'b1; s_ena_a[v] = '0; s_in_a[v] = '0; zrdy_a[v] = 1'b0;
                zen_i_a[v] = 1'b0; zin_a[v] = '0; rdyin_a[v] = 1'b0;
            end
        end
        for (int s = 0; s < 3; s++) begin
            e[s] = (src_size(s) > 0) && mask[s];
            d[s] = 11'(src_front(s));
        end
        rst_a[u]   = rst_v;
        s_ena_a[u] = e;
        s_in_a[u]  = d;
        zrdy_a[u]  = zz_rdy_v;
        zen_i_a[u] = force_zz || (zq.size() > 0);
        zin_a[u]   = (zq.size() > 0) ? 11'(zq[0]) : 11'd0;
        rdyin_a[u] = rdy_v;
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // One clock: drive, check everything visible this cycle, then advance the model.
    task automatic tick();
        logic [2:0] e_rdy;
        bit   stall, e_zen, in_acc, out_acc, rst_s;
        int   cur, inc, dec;
        exp_t e;
        drive();
        #1;
        rst_s = rst_v;
        cur   = comp_of(m_iidx);
        stall = (m_infl == 2) && (m_ibeat == 0);
        e_rdy = (rst_s || !zz_rdy_v || stall) ? 3'b000 : 3'(1 << cur);
        checks++;
        if (s_rdy_a[u] !== e_rdy) begin
            errors++;
            $display("FAIL src_rdy cyc=%0d got=%b required=%b", cyc, s_rdy_a[u], e_rdy);
        end
        e_zen = !rst_s && !stall && (s_ena_a[u][cur] === 1'b1);
        checks++;
        if (zen_o_a[u] !== e_zen) begin
            errors++;
            $display("FAIL zz_ena_out cyc=%0d got=%b required=%b", cyc, zen_o_a[u], e_zen);
        end
        if (e_zen) begin
            checks++;
            if (zout_a[u] !== 11'(src_front(cur))) begin
                errors++;
                $display("FAIL zz_out cyc=%0d got=%0d required=%0d", cyc, zout_a[u], src_front(cur));
            end
        end
        checks++;
        if (zrdy_o_a[u] !== (rdy_v && !rst_s)) begin
            errors++;
            $display("FAIL zz_rdy_out cyc=%0d got=%b required=%b", cyc, zrdy_o_a[u], rdy_v && !rst_s);
        end
        checks++;
        if (ena_a[u] !== zen_i_a[u]) begin
            errors++;
            $display("FAIL ena_out cyc=%0d got=%b required=%b", cyc, ena_a[u], zen_i_a[u]);
        end
        if (zen_i_a[u] === 1'b1) begin
            checks++;
            if (out_a[u] !== zin_a[u]) begin
                errors++;
                $display("FAIL out_pass cyc=%0d got=%0d required=%0d", cyc, out_a[u], zin_a[u]);
            end
        end
        checks++;
        if (err_a[u] !== err_exp) begin
            errors++;
            $display("FAIL err_out cyc=%0d got=%b required=%b", cyc, err_a[u], err_exp);
        end
        in_acc  = !rst_s && (zen_o_a[u] === 1'b1) && zz_rdy_v;
        out_acc = !rst_s && (zen_i_a[u] === 1'b1) && rdy_v;
        if (out_acc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat cyc=%0d got data=%0d, required no beat", cyc, out_a[u]);
            end else begin
                e = exp_q.pop_front();
                if (out_a[u] !== 11'(e.data) || comp_a[u] !== 2'(e.comp) || sob_a[u] !== e.sob
                    || eob_a[u] !== e.eob || eom_a[u] !== e.eom) begin
                    errors++;
                    $display("FAIL out_beat cyc=%0d got d=%0d c=%0d s/e/m=%b%b%b required d=%0d c=%0d s/e/m=%b%b%b",
                             cyc, out_a[u], comp_a[u], sob_a[u], eob_a[u], eom_a[u],
                             e.data, e.comp, e.sob, e.eob, e.eom);
                end
            end
            obeat_cnt++;
            if (eom_a[u] === 1'b1) begin
                eom_cnt++;
                eom_at = obeat_cnt;
            end
            if (sob_a[u] === 1'b1) comp_log.push_back(int'(comp_a[u]));
            if (track && m_obeat == 63 && first_eob < 0) first_eob = cyc;
        end
        if (in_acc && track && m_ibeat == 0 && first_start < 0) first_start = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst_s) begin
            reset_model();
        end else begin
            inc = 0;
            dec = 0;
            if (zen_i_a[u] === 1'b1 && m_infl == 0) err_exp = 1;
            if (out_acc) begin
                if (zq.size() > 0) void'(zq.pop_front());
                if (m_obeat == 63) begin
                    dec = 1;
                    m_obeat = 0;
                end else begin
                    m_obeat++;
                end
            end
            if (in_acc) begin
                wr_buf[m_ibeat] = src_front(cur);
                src_pop(cur);
                if (m_ibeat == 0) begin
                    inc = 1;
                    blocks_in++;
                end
                if (m_ibeat == 63) begin
                    for (int j = 0; j < 64; j++) zq.push_back(wr_buf[zz[j]]);
                    m_ibeat = 0;
                    m_iidx = (m_iidx == ypm + 1) ? 0 : m_iidx + 1;
                end else begin
                    m_ibeat++;
                end
            end
            m_infl = m_infl + inc - dec;
        end
    endtask

    task automatic run_drain(input int limit);
        int n = 0;
        while ((exp_q.size() > 0 || src_size(0) + src_size(1) + src_size(2) > 0) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_v = 1;
        settle();
        checks++;
        if (s_rdy_a[u] !== 3'b000 || zen_o_a[u] !== 1'b0 || zrdy_o_a[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy got src=%b zz_ena=%b zz_rdy=%b required 000/0/0",
                     s_rdy_a[u], zen_o_a[u], zrdy_o_a[u]);
        end
        tick();
        tick();
        rst_v = 0;
        settle();
        checks++;
        if (s_rdy_a[u] !== 3'b001 || err_a[u] !== 1'b0 || ena_a[u] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got src=%b err=%b ena=%b required 001/0/0",
                     s_rdy_a[u], err_a[u], ena_a[u]);
        end
        tick();
    endtask

    task automatic test_mcu_420();
        obeat_cnt = 0; eom_cnt = 0; eom_at = 0;
        load_mcu();
        run_drain(3000);
        checks++;
        if (obeat_cnt != 384 || eom_cnt != 1 || eom_at != 384) begin
            errors++;
            $display("FAIL mcu_420_eom got beats=%0d eoms=%0d at=%0d required 384/1/384",
                     obeat_cnt, eom_cnt, eom_at);
        end
    endtask

    task automatic test_cb_first();
        load_blk(1);
        for (int i = 0; i < 20; i++) begin
            settle();
            checks++;
            if (s_rdy_a[u] !== 3'b001 || zen_o_a[u] !== 1'b0) begin
                errors++;
                $display("FAIL cb_first_rdy got src=%b zz_ena=%b required 001/0", s_rdy_a[u], zen_o_a[u]);
            end
            tick();
        end
        checks++;
        if (src_size(1) != 64) begin
            errors++;
            $display("FAIL cb_first_taken got %0d Cb beats left, required 64", src_size(1));
        end
        for (int b = 0; b < 4; b++) load_blk(0);
        load_blk(2);
        push_exp();
        run_drain(3000);
    endtask

    task automatic test_hold();
        int b0;
        b0 = blocks_in;
        rdy_v = 0;
        load_mcu();
        repeat (300) tick();
        settle();
        checks++;
        if (blocks_in - b0 != 2 || s_rdy_a[u] !== 3'b000 || ena_a[u] !== 1'b1) begin
            errors++;
            $display("FAIL hold_cap got blocks=%0d src=%b ena=%b required 2/000/1",
                     blocks_in - b0, s_rdy_a[u], ena_a[u]);
        end
        rdy_v = 1;
        track = 1; first_eob = -1; first_start = -1;
        run_drain(3000);
        track = 0;
        checks++;
        if (first_eob < 0 || first_start != first_eob + 1) begin
            errors++;
            $display("FAIL hold_resume got start=%0d required eob+1=%0d", first_start, first_eob + 1);
        end
    endtask

    task automatic test_ena_drop();
        int n = 0;
        load_mcu();
        while (!(m_iidx == 0 && m_ibeat == 30) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL ena_drop_reach got beat=%0d required 30", m_ibeat);
        end
        mask[0] = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (s_rdy_a[u] !== 3'b001 || zen_o_a[u] !== 1'b0) begin
                errors++;
                $display("FAIL ena_drop_grant got src=%b zz_ena=%b required 001/0", s_rdy_a[u], zen_o_a[u]);
            end
            tick();
        end
        mask[0] = 1;
        run_drain(3000);
    endtask

    task automatic test_rst_mid();
        int n = 0;
        int b0;
        load_mcu();
        while (!(m_iidx == 2 && m_ibeat == 20) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL rst_mid_reach got idx=%0d beat=%0d required 2/20", m_iidx, m_ibeat);
        end
        rst_v = 1;
        settle();
        checks++;
        if (s_rdy_a[u] !== 3'b000 || zen_o_a[u] !== 1'b0 || zrdy_o_a[u] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rdy got src=%b zz_ena=%b zz_rdy=%b required 000/0/0",
                     s_rdy_a[u], zen_o_a[u], zrdy_o_a[u]);
        end
        tick();
        rst_v = 0;
        settle();
        checks++;
        if (s_rdy_a[u] !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_grant got src=%b required 001", s_rdy_a[u]);
        end
        b0 = blocks_in;
        rdy_v = 0;
        load_mcu();
        repeat (300) tick();
        checks++;
        if (blocks_in - b0 != 2) begin
            errors++;
            $display("FAIL rst_mid_inflight got blocks=%0d required 2", blocks_in - b0);
        end
        rdy_v = 1;
        run_drain(3000);
    endtask

    task automatic test_err();
        rdy_v = 0;
        force_zz = 1;
        settle();
        checks++;
        if (err_a[u] !== 1'b0) begin
            errors++;
            $display("FAIL err_pre got=%b required=0", err_a[u]);
        end
        tick();
        force_zz = 0;
        settle();
        checks++;
        if (err_a[u] !== 1'b1) begin
            errors++;
            $display("FAIL err_set got=%b required=1", err_a[u]);
        end
        repeat (5) tick();
        rst_v = 1;
        tick();
        rst_v = 0;
        rdy_v = 1;
        settle();
        checks++;
        if (err_a[u] !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b required=0", err_a[u]);
        end
        tick();
    endtask

    task automatic test_ypm1();
        int ref_c [6] = '{0, 1, 2, 0, 1, 2};
        u = 1;
        ypm = 1;
        reset_model();
        rst_v = 1;
        tick();
        rst_v = 0;
        comp_log.delete();
        load_mcu();
        load_mcu();
        run_drain(3000);
        checks++;
        if (comp_log.size() != 6) begin
            errors++;
            $display("FAIL ypm1_blocks got=%0d required=6", comp_log.size());
        end
        for (int i = 0; i < 6 && i < comp_log.size(); i++) begin
            checks++;
            if (comp_log[i] != ref_c[i]) begin
                errors++;
                $display("FAIL ypm1_comp block=%0d got=%0d required=%0d", i, comp_log[i], ref_c[i]);
            end
        end
    endtask

    initial begin
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
        reset_model();
        drive();
        test_reset();
        test_mcu_420();
        test_cb_first();
        test_hold();
        test_ena_drop();
        test_rst_mid();
        test_err();
        test_ypm1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
